memory_interface: RTL and testbench
===================================

Name: memory_interface

Overview:
- Bus-side stage directly downstream of the CPU address register: consumes the registered memory address and the write data, and runs one handshaked transaction per request to the external memory.
- Handles word and byte accesses, lane steering and read-data extraction, and a wait-state timeout.
- Returns read data to the core's data-in path and signals completion or abort to the control unit.

Parameters:
- TIMEOUT, 16: maximum cycles mem_valid is held without mem_ready before aborting; 0 disables the timeout.
- CNT_W, 8: width of the wait-state counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  access request from control unit; sampled only in IDLE
- we  in  1  1 = write, 0 = read
- byte  in  1  1 = byte access, 0 = word access
- addr  in  32  address from address register (memory output)
- wdata  in  32  write data from data-out register
- rdata  out  32  read result; byte reads zero-extended
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- abort  out  1  one-cycle pulse on misaligned word access or timeout
- mem_addr  out  32  word-aligned address {a[31:2],2'b00}
- mem_wdata  out  32  write data, lane-steered
- mem_be  out  4  byte enables
- mem_we  out  1  write strobe, qualified by mem_valid
- mem_valid  out  1  request valid
- mem_ready  in  1  memory accepts/completes the transaction
- mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- States: IDLE, REQ, RESP, ERR. Reset forces IDLE.
- Reset values: rdata, mem_addr, mem_wdata and counter are 0; mem_be is 4'h0; all 1-bit outputs are 0. Reset acts immediately, mid-transaction included: mem_valid drops at once and no done/abort pulse is produced.
- IDLE, req=1 at edge: latch addr, we, byte and wdata.
  - If byte=0 and addr[1:0]!=0: go to ERR.
  - Otherwise: go to REQ and clear the counter.
  - req is ignored in all other states.
- REQ:
  - mem_valid=1; mem_addr, mem_we, mem_be and mem_wdata are held stable from the latched values.
  - On an edge with mem_ready=1: for a read, capture rdata; go to RESP.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: go to ERR. Else counter+1.
  - mem_ready wins over the timeout on the same edge. mem_valid is therefore high for at most TIMEOUT cycles.
- RESP: done=1 for one cycle, then IDLE. Writes leave rdata unchanged.
- ERR: abort=1 for one cycle, mem_valid=0, then IDLE. rdata is unchanged.
- Lane rules, little-endian, n = addr[1:0]:
  - Word access: mem_be=4'hF, mem_wdata=wdata.
  - Byte access: mem_be=1<<n, mem_wdata = wdata[7:0] replicated into all four lanes.
  - Byte read: rdata = {24'b0, mem_rdata[8n+7:8n]}.
- Outside REQ: mem_valid=0, mem_we=0, mem_be=0; mem_ready is ignored.
- Latency: req accepted at edge k → mem_valid high after k. Ready at edge k+j (j≥1) → done high during the cycle after k+j. Minimum req-to-done is 2 edges. rdata is valid when done is high and holds until the next successful read.
- Back-to-back: a new req is accepted no earlier than the edge that leaves RESP/ERR, i.e. the first IDLE cycle.

Test Plan:
- Word read, addr=0x0000_1004, mem_ready high in the first REQ cycle with mem_rdata=0xDEAD_BEEF → mem_addr=0x1004, mem_be=F, mem_we=0; done one cycle later; rdata=0xDEADBEEF.
- Byte read, addr=0x2003, mem_rdata=0x11223344, ready after 3 wait cycles → mem_be=4'b1000; rdata=0x00000011; busy high for 5 cycles.
- Byte write, addr=0x2001, wdata=0xAABBCC5A → mem_wdata=0x5A5A5A5A, mem_be=4'b0010, mem_we=1; done pulses; rdata unchanged.
- Misaligned word write, addr=0x3002 → mem_valid never asserts; abort pulses one cycle after acceptance; state returns to IDLE.
- Timeout, TIMEOUT=4, mem_ready held 0 → mem_valid high exactly 4 cycles, then abort pulse. Repeat with ready=1 on the 4th cycle → done, no abort.
- Reset asserted asynchronously mid-REQ → mem_valid drops before the next edge; no done/abort; next req is accepted normally.

Source files
------------

// File: rtl/memory_interface_if.sv
// External memory bus: one handshaked beat per request, valid held until ready.
interface memory_interface_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_we, mem_valid,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_valid,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/memory_interface.sv
// Bus-side memory stage: one handshaked transaction per core request, with
// byte-lane steering, read-data extraction and a wait-state timeout.
module memory_interface_lane (
  input  logic       byte_acc,
  input  logic       hit,
  input  logic [7:0] wbyte,
  input  logic [7:0] wlo,
  output logic       be,
  output logic [7:0] wout
);
  // Byte stores broadcast the low byte to every lane; the enable picks the target.
  assign be   = byte_acc ? hit : 1'b1;
  assign wout = byte_acc ? wlo : wbyte;
endmodule

module memory_interface #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic                byte_acc,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                busy,
  output logic                done,
  output logic                abort,
  memory_interface_if.master  mem
);
  localparam int NUM_LANES = 4;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t state_q, state_d;

  logic                        we_l, byte_l;
  logic [1:0]                  lane_l;
  logic [31:0]                 maddr_q;
  logic [NUM_LANES-1:0]        be_l;
  logic [NUM_LANES-1:0][7:0]   wdata_l;
  logic [CNT_W-1:0]            cnt_q;

  logic                        accept, capture, timeout_hit, in_req;
  logic [NUM_LANES-1:0]        be_n;
  logic [NUM_LANES-1:0][7:0]   wd_n;
  logic [NUM_LANES-1:0][7:0]   rd_lanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    memory_interface_lane u_lane (
      .byte_acc (byte_acc),
      .hit      (addr[1:0] == 2'(i)),
      .wbyte    (wdata[8*i +: 8]),
      .wlo      (wdata[7:0]),
      .be       (be_n[i]),
      .wout     (wd_n[i])
    );
  end

  assign rd_lanes    = mem.mem_rdata;
  assign in_req      = (state_q == REQ);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        accept  = 1'b1;
        state_d = (!byte_acc && addr[1:0] != 2'b00) ? ERR : REQ;
      end
      // Ready takes priority over an expiring wait counter on the same edge.
      REQ: if (mem.mem_ready) begin
        capture = !we_l;
        state_d = RESP;
      end else if (timeout_hit) begin
        state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_l    <= 1'b0;
      byte_l  <= 1'b0;
      lane_l  <= 2'b00;
      maddr_q <= '0;
      be_l    <= '0;
      wdata_l <= '0;
      cnt_q   <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_l    <= we;
        byte_l  <= byte_acc;
        lane_l  <= addr[1:0];
        maddr_q <= {addr[31:2], 2'b00};
        be_l    <= be_n;
        wdata_l <= wd_n;
        cnt_q   <= '0;
      end else if (in_req && !mem.mem_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture)
        rdata <= byte_l ? {24'b0, rd_lanes[lane_l]} : mem.mem_rdata;
    end
  end

  assign mem.mem_valid = in_req;
  assign mem.mem_we    = we_l & in_req;
  assign mem.mem_be    = be_l & {NUM_LANES{in_req}};
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_l;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == RESP);
  assign abort = (state_q == ERR);
endmodule

// File: tb/tb_memory_interface.sv
// Scoreboard bench for memory_interface: expected bus beats and core responses
// are queued at issue time and retired by a negedge monitor.
module tb_memory_interface;
  logic        clk, reset, req, we, byte_acc;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, abort;

  memory_interface_if mif();

  memory_interface #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_acc(byte_acc),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .abort(abort), .mem(mif)
  );

  typedef struct packed {logic is_abort; logic [31:0] rdata;} resp_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we;} beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  int n_chk = 0, n_fail = 0;
  int busy_cyc = 0, valid_cyc = 0;
  int mem_wait = 0, vcnt = 0;
  logic [31:0] mem_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: raises ready after mem_wait valid cycles (-1 = never).
  always @(posedge clk) begin
    #1;
    if (mif.mem_valid) begin
      mif.mem_ready = (vcnt == mem_wait);
      vcnt++;
    end else begin
      mif.mem_ready = 1'b0;
      vcnt = 0;
    end
    mif.mem_rdata = mem_data;
  end

  always @(negedge clk) begin : mon
    beat_t b;
    resp_t r;
    if (mif.mem_valid && mif.mem_ready) begin
      if (beat_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: got addr %h expected no beat", mif.mem_addr);
      end else begin
        b = beat_q.pop_front();
        check("beat_addr",  mif.mem_addr,  b.addr);
        check("beat_wdata", mif.mem_wdata, b.wdata);
        check("beat_be",    32'(mif.mem_be), 32'(b.be));
        check("beat_we",    32'(mif.mem_we), 32'(b.we));
      end
    end
    if (done || abort) begin
      if (resp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_resp: got done=%0b abort=%0b expected none", done, abort);
      end else begin
        r = resp_q.pop_front();
        check("resp_done",  32'(done),  32'(!r.is_abort));
        check("resp_abort", 32'(abort), 32'(r.is_abort));
        check("resp_rdata", rdata, r.rdata);
      end
    end
    if (busy) busy_cyc++;
    if (mif.mem_valid) valid_cyc++;
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 40 cycles");
    end
  endtask

  task automatic push_beat(input logic [31:0] a, d, input logic [3:0] be, input logic w);
    beat_t b;
    b.addr = a; b.wdata = d; b.be = be; b.we = w;
    beat_q.push_back(b);
  endtask

  task automatic push_resp(input logic ab, input logic [31:0] rd);
    resp_t r;
    r.is_abort = ab; r.rdata = rd;
    resp_q.push_back(r);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic txn(input logic w, b, input logic [31:0] a, d, md, input int mw,
                     input int exp_busy, input int exp_valid);
    mem_data = md; mem_wait = mw; busy_cyc = 0; valid_cyc = 0;
    we = w; byte_acc = b; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_idle();
    check("busy_cycles",  32'(busy_cyc),  32'(exp_busy));
    check("valid_cycles", 32'(valid_cyc), 32'(exp_valid));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; byte_acc = 1'b0; addr = '0; wdata = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    #12;
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_mem_wdata", mif.mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mif.mem_be), 32'h0);
    check("rst_flags", {27'b0, busy, done, abort, mif.mem_valid, mif.mem_we}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);

    // word read, ready in first REQ cycle
    push_beat(32'h0000_1004, 32'h0, 4'hF, 1'b0); push_resp(1'b0, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 2, 1);
    // byte read lane 3, three wait cycles
    push_beat(32'h0000_2000, 32'h0, 4'b1000, 1'b0); push_resp(1'b0, 32'h0000_0011);
    txn(1'b0, 1'b1, 32'h0000_2003, 32'h0, 32'h1122_3344, 3, 5, 4);
    // byte write lane 1, rdata untouched
    push_beat(32'h0000_2000, 32'h5A5A_5A5A, 4'b0010, 1'b1); push_resp(1'b0, 32'h0000_0011);
    txn(1'b1, 1'b1, 32'h0000_2001, 32'hAABB_CC5A, 32'hFFFF_FFFF, 1, 3, 2);
    // misaligned word write -> abort without a bus cycle
    push_resp(1'b1, 32'h0000_0011);
    txn(1'b1, 1'b0, 32'h0000_3002, 32'h1234_5678, 32'h0, 0, 1, 0);
    // timeout: valid for exactly 4 cycles
    push_resp(1'b1, 32'h0000_0011);
    txn(1'b0, 1'b0, 32'h0000_4000, 32'h0, 32'h0, -1, 5, 4);
    // ready on the last allowed cycle wins over timeout
    push_beat(32'h0000_4008, 32'h0, 4'hF, 1'b0); push_resp(1'b0, 32'hCAFE_F00D);
    txn(1'b0, 1'b0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 3, 5, 4);
    // remaining byte lanes
    push_beat(32'h0000_5000, 32'h0, 4'b0010, 1'b0); push_resp(1'b0, 32'h0000_0033);
    txn(1'b0, 1'b1, 32'h0000_5001, 32'h0, 32'h1122_3344, 0, 2, 1);
    push_beat(32'h0000_5000, 32'h0, 4'b0001, 1'b0); push_resp(1'b0, 32'h0000_0044);
    txn(1'b0, 1'b1, 32'h0000_5000, 32'h0, 32'h1122_3344, 0, 2, 1);
    push_beat(32'h0000_5000, 32'h0, 4'b0100, 1'b0); push_resp(1'b0, 32'h0000_0022);
    txn(1'b0, 1'b1, 32'h0000_5002, 32'h0, 32'h1122_3344, 0, 2, 1);
    push_beat(32'h0000_6000, 32'hA5A5_A5A5, 4'b1000, 1'b1); push_resp(1'b0, 32'h0000_0022);
    txn(1'b1, 1'b1, 32'h0000_6003, 32'h1234_56A5, 32'h0, 0, 2, 1);
    push_beat(32'h0000_7000, 32'h1234_5678, 4'hF, 1'b1); push_resp(1'b0, 32'h0000_0022);
    txn(1'b1, 1'b0, 32'h0000_7000, 32'h1234_5678, 32'h0, 2, 4, 3);
    push_resp(1'b1, 32'h0000_0022);
    txn(1'b0, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 0);

    // asynchronous reset while waiting in REQ
    mem_wait = -1; we = 1'b0; byte_acc = 1'b0; addr = 32'h0000_8000; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(mif.mem_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(mif.mem_valid), 32'h0);
    check("async_rst_flags", {29'b0, busy, done, abort}, 32'h0);
    check("async_rst_rdata", rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    push_beat(32'h0000_9000, 32'h0, 4'hF, 1'b0); push_resp(1'b0, 32'h0BAD_F00D);
    txn(1'b0, 1'b0, 32'h0000_9000, 32'h0, 32'h0BAD_F00D, 0, 2, 1);

    repeat (3) @(negedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 32'h0);
    check("beat_q_drained", 32'(beat_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
